// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the instruction/data memory port arbiter:
//   - load/store width codes carried on d_width
//   - arbiter state encodings
//   - default SRAM word-address width and data burst limit
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int MEM_AW_DEFAULT         = 12;
    localparam int MAX_DATA_BURST_DEFAULT = 4;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'b00,
        WIDTH_HALF = 2'b01,
        WIDTH_WORD = 2'b10,
        WIDTH_ILL  = 2'b11
    } width_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_FETCH_HI = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_lane_fmt.sv
// -----------------------------------------------------------------------------
// mem_lane_fmt
// Purely combinational byte-lane formatter shared by the request and the
// response side of the data port.
//   Request side (grant cycle):
//     req_width_i, req_addr_lo_i, req_wdata_i -> req_wstrb_o, req_wdata_o,
//     req_err_o (misaligned access or illegal width)
//   Response side (cycle after grant):
//     rsp_width_i, rsp_sign_i, rsp_addr_lo_i, rsp_rdata_i -> rsp_data_o
//     (lane extracted and zero/sign extended)
// -----------------------------------------------------------------------------
module mem_lane_fmt
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]  req_width_i,
    input  logic [1:0]  req_addr_lo_i,
    input  logic [31:0] req_wdata_i,
    output logic [3:0]  req_wstrb_o,
    output logic [31:0] req_wdata_o,
    output logic        req_err_o,
    input  logic [1:0]  rsp_width_i,
    input  logic        rsp_sign_i,
    input  logic [1:0]  rsp_addr_lo_i,
    input  logic [31:0] rsp_rdata_i,
    output logic [31:0] rsp_data_o
);

    // Store strobes, lane-shifted write data and the alignment check.  The
    // write data is always shifted by the full byte offset; strobes decide
    // which lanes actually land in the SRAM.
    always_comb begin
        req_wstrb_o = 4'b0000;
        req_err_o   = 1'b0;
        req_wdata_o = req_wdata_i << {req_addr_lo_i, 3'b000};
        case (req_width_i)
            WIDTH_BYTE: req_wstrb_o = 4'b0001 << req_addr_lo_i;
            WIDTH_HALF: begin
                req_wstrb_o = 4'b0011 << {req_addr_lo_i[1], 1'b0};
                req_err_o   = req_addr_lo_i[0];
            end
            WIDTH_WORD: begin
                req_wstrb_o = 4'b1111;
                req_err_o   = (req_addr_lo_i != 2'b00);
            end
            default:    req_err_o = 1'b1;
        endcase
    end

    // Load lane extraction followed by zero or sign extension from the
    // width and signedness captured with the request.
    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    always_comb begin
        case (rsp_addr_lo_i)
            2'd0:    byteLane = rsp_rdata_i[7:0];
            2'd1:    byteLane = rsp_rdata_i[15:8];
            2'd2:    byteLane = rsp_rdata_i[23:16];
            default: byteLane = rsp_rdata_i[31:24];
        endcase
        halfLane = rsp_addr_lo_i[1] ? rsp_rdata_i[31:16] : rsp_rdata_i[15:0];

        rsp_data_o = 32'h0;
        case (rsp_width_i)
            WIDTH_BYTE: rsp_data_o = {{24{rsp_sign_i & byteLane[7]}}, byteLane};
            WIDTH_HALF: rsp_data_o = {{16{rsp_sign_i & halfLane[15]}}, halfLane};
            WIDTH_WORD: rsp_data_o = rsp_rdata_i;
            default:    rsp_data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port, byte-strobed, word-organised SRAM (1-cycle read
// latency) between the instruction-fetch port and the load/store port.
//   clk_i, rst_i          clock, synchronous active-high reset
//   if_*                  fetch port: req/addr in, gnt/rvalid/rdata/err out
//   d_*                   data port: req/we/width/sign/addr/wdata in,
//                         gnt/rvalid/rdata/err out
//   mem_*                 SRAM port: en/we/addr/wstrb/wdata out, rdata in
// A fetch with PC[1]=1 is split into two word reads (FETCH_HI state) and
// merged.  Data wins contention until it has taken MAX_DATA_BURST grants
// while a fetch waited, then the fetch is forced through.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_AW         = MEM_AW_DEFAULT,
    parameter int MAX_DATA_BURST = MAX_DATA_BURST_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    output logic                  if_err_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [1:0]            d_width_i,
    input  logic                  d_sign_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  d_err_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [MEM_AW-1:0]     mem_addr_o,
    output logic [3:0]            mem_wstrb_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int               CNT_W   = $clog2(MAX_DATA_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DATA_BURST);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  starveCnt_q, starveCnt_d;
    logic [MEM_AW-1:0] fetchWord_q, fetchWord_d;
    logic [15:0]       fetchLow_q;
    logic              ifWordRsp_q, ifSplitRsp_q, ifErr_q;
    logic              dRvalid_q, dLoad_q, dErr_q, dSign_q;
    logic [1:0]        dWidth_q, dLo_q;

    logic        inIdle, fetchHi, dStarved;
    logic        dGrant, ifGrant, dBad, dAccess, ifAccess, ifSplit;
    logic [3:0]  reqWstrb;
    logic [31:0] reqWdata, rspData;

    logic unused_hiAddrBits;
    assign unused_hiAddrBits = ^{if_addr_i[ADDR_WIDTH-1:MEM_AW+2],
                                 d_addr_i[ADDR_WIDTH-1:MEM_AW+2]};

    // One formatter serves both the outgoing request (strobes, shift,
    // alignment) and the returning load data using the captured attributes.
    mem_lane_fmt u_lane_fmt (
        .req_width_i   (d_width_i),
        .req_addr_lo_i (d_addr_i[1:0]),
        .req_wdata_i   (d_wdata_i),
        .req_wstrb_o   (reqWstrb),
        .req_wdata_o   (reqWdata),
        .req_err_o     (dBad),
        .rsp_width_i   (dWidth_q),
        .rsp_sign_i    (dSign_q),
        .rsp_addr_lo_i (dLo_q),
        .rsp_rdata_i   (mem_rdata_i),
        .rsp_data_o    (rspData)
    );

    // Arbitration and SRAM drive for the current cycle.  Grants only happen
    // in IDLE and never while reset is asserted; the second beat of a split
    // fetch owns the SRAM in FETCH_HI.
    always_comb begin
        inIdle   = !rst_i && (state_q == ST_IDLE);
        fetchHi  = !rst_i && (state_q == ST_FETCH_HI);
        dStarved = (starveCnt_q == CNT_MAX);
        dGrant   = inIdle && d_req_i && (!if_req_i || !dStarved);
        ifGrant  = inIdle && if_req_i && !dGrant;
        dAccess  = dGrant && !dBad;
        ifAccess = ifGrant && !if_addr_i[0];
        ifSplit  = ifAccess && if_addr_i[1];

        mem_en_o    = dAccess || ifAccess || fetchHi;
        mem_we_o    = dAccess && d_we_i;
        mem_wstrb_o = mem_we_o ? reqWstrb : 4'b0000;
        mem_wdata_o = reqWdata;
        if (fetchHi)
            mem_addr_o = fetchWord_q + 1'b1;
        else if (dGrant)
            mem_addr_o = d_addr_i[MEM_AW+1:2];
        else
            mem_addr_o = if_addr_i[MEM_AW+1:2];
    end

    // Next-state values: the split fetch parks in FETCH_HI for one cycle;
    // the starvation counter only grows while a fetch is actually waiting.
    always_comb begin
        state_d     = ifSplit ? ST_FETCH_HI : ST_IDLE;
        fetchWord_d = ifSplit ? if_addr_i[MEM_AW+1:2] : fetchWord_q;
        starveCnt_d = starveCnt_q;
        if (!if_req_i || ifGrant)
            starveCnt_d = '0;
        else if (dGrant && !dStarved)
            starveCnt_d = starveCnt_q + 1'b1;
    end

    // All state and response registers.  Response flags are one-cycle
    // pulses derived from the grant cycle; the upper half of word A is
    // captured during FETCH_HI for merging with word A+1 a cycle later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            starveCnt_q  <= '0;
            fetchWord_q  <= '0;
            fetchLow_q   <= '0;
            ifWordRsp_q  <= 1'b0;
            ifSplitRsp_q <= 1'b0;
            ifErr_q      <= 1'b0;
            dRvalid_q    <= 1'b0;
            dLoad_q      <= 1'b0;
            dErr_q       <= 1'b0;
            dSign_q      <= 1'b0;
            dWidth_q     <= 2'b00;
            dLo_q        <= 2'b00;
        end else begin
            state_q      <= state_d;
            starveCnt_q  <= starveCnt_d;
            fetchWord_q  <= fetchWord_d;
            if (fetchHi)
                fetchLow_q <= mem_rdata_i[31:16];
            ifWordRsp_q  <= ifAccess && !if_addr_i[1];
            ifSplitRsp_q <= fetchHi;
            ifErr_q      <= ifGrant && if_addr_i[0];
            dRvalid_q    <= dGrant;
            dErr_q       <= dGrant && dBad;
            dLoad_q      <= dAccess && !d_we_i;
            if (dGrant) begin
                dWidth_q <= d_width_i;
                dSign_q  <= d_sign_i;
                dLo_q    <= d_addr_i[1:0];
            end
        end
    end

    // Response outputs; data buses are zero unless a matching pulse is up.
    always_comb begin
        if_gnt_o    = ifGrant;
        d_gnt_o     = dGrant;
        if_rvalid_o = ifWordRsp_q || ifSplitRsp_q || ifErr_q;
        if_err_o    = ifErr_q;
        d_rvalid_o  = dRvalid_q;
        d_err_o     = dErr_q;
        d_rdata_o   = dLoad_q ? rspData : '0;
        if (ifWordRsp_q)
            if_rdata_o = mem_rdata_i;
        else if (ifSplitRsp_q)
            if_rdata_o = {mem_rdata_i[15:0], fetchLow_q};
        else
            if_rdata_o = '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a behavioural 1-cycle SRAM.
// Single data transactions come from a vector table; fetch sequencing,
// contention and reset-in-FETCH_HI are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk, rst;
    logic        ifReq, ifGnt, ifRvalid, ifErr;
    logic [31:0] ifAddr, ifRdata;
    logic        dReq, dWe, dSign, dGnt, dRvalid, dErr;
    logic [1:0]  dWidth;
    logic [31:0] dAddr, dWdata, dRdata;
    logic        memEn, memWe;
    logic [11:0] memAddr;
    logic [3:0]  memWstrb;
    logic [31:0] memWdata, memRdata;
    logic        preload;

    int checks;
    int errors;

    logic [31:0] sram [0:4095];

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  width;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        expMemEn;
        logic [3:0]  expWstrb;
        logic [31:0] expWdata;
        logic        expErr;
        logic [31:0] expRdata;
    } dataVec_t;

    dataVec_t vecs [14];

    mem_port_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .if_req_i    (ifReq),
        .if_addr_i   (ifAddr),
        .if_gnt_o    (ifGnt),
        .if_rvalid_o (ifRvalid),
        .if_rdata_o  (ifRdata),
        .if_err_o    (ifErr),
        .d_req_i     (dReq),
        .d_we_i      (dWe),
        .d_width_i   (dWidth),
        .d_sign_i    (dSign),
        .d_addr_i    (dAddr),
        .d_wdata_i   (dWdata),
        .d_gnt_o     (dGnt),
        .d_rvalid_o  (dRvalid),
        .d_rdata_o   (dRdata),
        .d_err_o     (dErr),
        .mem_en_o    (memEn),
        .mem_we_o    (memWe),
        .mem_addr_o  (memAddr),
        .mem_wstrb_o (memWstrb),
        .mem_wdata_o (memWdata),
        .mem_rdata_i (memRdata)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM with byte strobes and 1-cycle reads.
    always @(posedge clk) begin
        if (preload) begin
            sram[12'h010] <= 32'h11223344;
            sram[12'h011] <= 32'hAABBCCDD;
        end else if (memEn) begin
            if (memWe) begin
                for (int b = 0; b < 4; b++)
                    if (memWstrb[b]) sram[memAddr][b*8 +: 8] <= memWdata[b*8 +: 8];
            end else begin
                memRdata <= sram[memAddr];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One data transaction: drive at a negedge, check the grant-cycle SRAM
    // drive, then check the response in the following cycle.
    task automatic applyStimulus(input dataVec_t v);
        @(negedge clk);
        dReq   = 1'b1;
        dWe    = v.we;
        dWidth = v.width;
        dSign  = v.sign;
        dAddr  = v.addr;
        dWdata = v.wdata;
        #1;
        checkOutput({v.name, " d_gnt"}, 32'(dGnt), 32'd1);
        checkOutput({v.name, " if_gnt"}, 32'(ifGnt), 32'd0);
        checkOutput({v.name, " mem_en"}, 32'(memEn), 32'(v.expMemEn));
        checkOutput({v.name, " mem_we"}, 32'(memWe), 32'(v.expMemEn & v.we));
        if (v.expMemEn)
            checkOutput({v.name, " mem_addr"}, 32'(memAddr), 32'(v.addr[13:2]));
        if (v.expMemEn && v.we) begin
            checkOutput({v.name, " mem_wstrb"}, 32'(memWstrb), 32'(v.expWstrb));
            checkOutput({v.name, " mem_wdata"}, memWdata, v.expWdata);
        end
        @(negedge clk);
        dReq = 1'b0;
        #1;
        checkOutput({v.name, " d_rvalid"}, 32'(dRvalid), 32'd1);
        checkOutput({v.name, " d_err"}, 32'(dErr), 32'(v.expErr));
        checkOutput({v.name, " d_rdata"}, dRdata, v.expRdata);
    endtask

    // Expected grant pattern for contention: 1 = data, 0 = fetch.
    logic expSeqA [10];
    logic expSeqB [8];

    initial begin
        checks = 0;
        errors = 0;

        //                name            we    wid   sg    addr   wdata         en    strb     wdata        err   rdata
        vecs[0]  = '{"ldb_s_44",    1'b0, 2'b00, 1'b1, 32'h44, 32'h0,        1'b1, 4'b0000, 32'h0,        1'b0, 32'hFFFFFFDD};
        vecs[1]  = '{"ldb_u_43",    1'b0, 2'b00, 1'b0, 32'h43, 32'h0,        1'b1, 4'b0000, 32'h0,        1'b0, 32'h00000011};
        vecs[2]  = '{"ldh_u_46",    1'b0, 2'b01, 1'b0, 32'h46, 32'h0,        1'b1, 4'b0000, 32'h0,        1'b0, 32'h0000AABB};
        vecs[3]  = '{"ldh_s_46",    1'b0, 2'b01, 1'b1, 32'h46, 32'h0,        1'b1, 4'b0000, 32'h0,        1'b0, 32'hFFFFAABB};
        vecs[4]  = '{"ldw_44",      1'b0, 2'b10, 1'b0, 32'h44, 32'h0,        1'b1, 4'b0000, 32'h0,        1'b0, 32'hAABBCCDD};
        vecs[5]  = '{"ldb_s_40",    1'b0, 2'b00, 1'b1, 32'h40, 32'h0,        1'b1, 4'b0000, 32'h0,        1'b0, 32'h00000044};
        vecs[6]  = '{"ldh_s_44",    1'b0, 2'b01, 1'b1, 32'h44, 32'h0,        1'b1, 4'b0000, 32'h0,        1'b0, 32'hFFFFCCDD};
        vecs[7]  = '{"stb_41",      1'b1, 2'b00, 1'b0, 32'h41, 32'h000000EE, 1'b1, 4'b0010, 32'h0000EE00, 1'b0, 32'h0};
        vecs[8]  = '{"ldw_40_a",    1'b0, 2'b10, 1'b0, 32'h40, 32'h0,        1'b1, 4'b0000, 32'h0,        1'b0, 32'h1122EE44};
        vecs[9]  = '{"ldh_err_41",  1'b0, 2'b01, 1'b0, 32'h41, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b1, 32'h0};
        vecs[10] = '{"ldw_err_42",  1'b0, 2'b10, 1'b0, 32'h42, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b1, 32'h0};
        vecs[11] = '{"ld_ill_40",   1'b0, 2'b11, 1'b0, 32'h40, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b1, 32'h0};
        vecs[12] = '{"sth_42",      1'b1, 2'b01, 1'b0, 32'h42, 32'h00001234, 1'b1, 4'b1100, 32'h12340000, 1'b0, 32'h0};
        vecs[13] = '{"ldw_40_b",    1'b0, 2'b10, 1'b0, 32'h40, 32'h0,        1'b1, 4'b0000, 32'h0,        1'b0, 32'h1234EE44};

        expSeqA = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        expSeqB = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset with both requesters pushing: nothing may be granted.
        rst = 1'b1; preload = 1'b1;
        ifReq = 1'b1; ifAddr = 32'h40;
        dReq = 1'b1; dWe = 1'b0; dWidth = 2'b10; dSign = 1'b0; dAddr = 32'h40; dWdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        #1;
        checkOutput("rst if_gnt", 32'(ifGnt), 32'd0);
        checkOutput("rst d_gnt", 32'(dGnt), 32'd0);
        checkOutput("rst mem_en", 32'(memEn), 32'd0);
        checkOutput("rst if_rvalid", 32'(ifRvalid), 32'd0);
        checkOutput("rst d_rvalid", 32'(dRvalid), 32'd0);
        checkOutput("rst errs", {30'd0, ifErr, dErr}, 32'd0);
        checkOutput("rst if_rdata", ifRdata, 32'd0);
        checkOutput("rst d_rdata", dRdata, 32'd0);
        ifReq = 1'b0; dReq = 1'b0; rst = 1'b0;

        // Aligned fetch.
        @(negedge clk);
        ifReq = 1'b1; ifAddr = 32'h40;
        #1;
        checkOutput("fa if_gnt", 32'(ifGnt), 32'd1);
        checkOutput("fa mem_en", 32'(memEn), 32'd1);
        checkOutput("fa mem_addr", 32'(memAddr), 32'h10);
        @(negedge clk);
        ifReq = 1'b0;
        #1;
        checkOutput("fa if_rvalid", 32'(ifRvalid), 32'd1);
        checkOutput("fa if_err", 32'(ifErr), 32'd0);
        checkOutput("fa if_rdata", ifRdata, 32'h11223344);

        // Split fetch with a data request arriving during FETCH_HI.
        @(negedge clk);
        ifReq = 1'b1; ifAddr = 32'h42;
        #1;
        checkOutput("fs if_gnt", 32'(ifGnt), 32'd1);
        checkOutput("fs mem_addr T", 32'(memAddr), 32'h10);
        @(negedge clk);
        ifReq = 1'b0;
        dReq = 1'b1; dWe = 1'b0; dWidth = 2'b10; dSign = 1'b0; dAddr = 32'h40;
        #1;
        checkOutput("fs d_gnt T1", 32'(dGnt), 32'd0);
        checkOutput("fs mem_en T1", 32'(memEn), 32'd1);
        checkOutput("fs mem_addr T1", 32'(memAddr), 32'h11);
        checkOutput("fs if_rvalid T1", 32'(ifRvalid), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("fs if_rvalid T2", 32'(ifRvalid), 32'd1);
        checkOutput("fs if_rdata", ifRdata, 32'hCCDD1122);
        checkOutput("fs d_gnt T2", 32'(dGnt), 32'd1);
        @(negedge clk);
        dReq = 1'b0;
        #1;
        checkOutput("fs d_rvalid", 32'(dRvalid), 32'd1);
        checkOutput("fs d_rdata", dRdata, 32'h11223344);

        // Odd fetch address: error response, no SRAM access.
        @(negedge clk);
        ifReq = 1'b1; ifAddr = 32'h41;
        #1;
        checkOutput("fe if_gnt", 32'(ifGnt), 32'd1);
        checkOutput("fe mem_en", 32'(memEn), 32'd0);
        @(negedge clk);
        ifReq = 1'b0;
        #1;
        checkOutput("fe if_rvalid", 32'(ifRvalid), 32'd1);
        checkOutput("fe if_err", 32'(ifErr), 32'd1);
        checkOutput("fe if_rdata", ifRdata, 32'd0);

        // Table of single data transactions.
        for (int i = 0; i < 14; i++)
            applyStimulus(vecs[i]);

        // Contention with both requests held high.
        @(negedge clk);
        ifReq = 1'b1; ifAddr = 32'h40;
        dReq = 1'b1; dWe = 1'b0; dWidth = 2'b10; dSign = 1'b0; dAddr = 32'h44;
        for (int i = 0; i < 10; i++) begin
            #1;
            checkOutput($sformatf("contA gnt %0d", i), {30'd0, dGnt, ifGnt}, {30'd0, expSeqA[i], ~expSeqA[i]});
            @(negedge clk);
        end
        ifReq = 1'b0; dReq = 1'b0;
        @(negedge clk);

        // Contention where the fetch request drops for one cycle mid-burst.
        ifReq = 1'b1; dReq = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ifReq = (i != 2);
            #1;
            checkOutput($sformatf("contB gnt %0d", i), {30'd0, dGnt, ifGnt}, {30'd0, expSeqB[i], ifReq & ~expSeqB[i]});
            @(negedge clk);
        end
        ifReq = 1'b0; dReq = 1'b0;
        @(negedge clk);

        // Reset asserted while the split fetch sits in FETCH_HI.
        @(negedge clk);
        ifReq = 1'b1; ifAddr = 32'h42;
        #1;
        checkOutput("rfh if_gnt", 32'(ifGnt), 32'd1);
        @(negedge clk);
        ifReq = 1'b0; rst = 1'b1;
        #1;
        checkOutput("rfh mem_en", 32'(memEn), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("rfh if_rvalid", 32'(ifRvalid), 32'd0);
        checkOutput("rfh if_rdata", ifRdata, 32'd0);
        checkOutput("rfh d_rvalid", 32'(dRvalid), 32'd0);
        checkOutput("rfh mem_en rst", 32'(memEn), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rfh if_rvalid late", 32'(ifRvalid), 32'd0);
        ifReq = 1'b1; ifAddr = 32'h40;
        #1;
        checkOutput("rfh regrant", 32'(ifGnt), 32'd1);
        checkOutput("rfh regrant addr", 32'(memAddr), 32'h10);
        @(negedge clk);
        ifReq = 1'b0;
        #1;
        checkOutput("rfh rvalid", 32'(ifRvalid), 32'd1);
        checkOutput("rfh rdata", ifRdata, 32'h1234EE44);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, word-organised, byte-strobed SRAM between the instruction-fetch port and the MEM-stage load/store port.
- Read latency is one cycle.
- Sequences a halfword-aligned instruction fetch (PC[1]=1) as two word reads and merges them.
- Formats load data by width and sign, and generates store strobes and shifted write data.
- Sits between the IF/MEM pipeline stages and the unified instruction/data memory array.

Parameters:
ADDR_WIDTH, 32, byte-address width of both requester ports
DATA_WIDTH, 32, word width; fixed at 32
MEM_AW, 12, SRAM word-address width (byte address bits [MEM_AW+1:2])
MAX_DATA_BURST, 4, consecutive data grants allowed while a fetch is pending before fetch is forced

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_WIDTH  fetch byte address
if_gnt  out  1  fetch accepted this cycle (combinational)
if_rvalid  out  1  fetch data valid, one-cycle pulse
if_rdata  out  32  instruction
if_err  out  1  qualifies if_rvalid: if_addr[0]=1
d_req  in  1  data request; held until d_gnt
d_we  in  1  1=store, 0=load
d_width  in  2  00 byte, 01 half, 10 word, 11 illegal
d_sign  in  1  sign-extend load
d_addr  in  ADDR_WIDTH  data byte address
d_wdata  in  32  store data, LSB-aligned
d_gnt  out  1  data accepted this cycle (combinational)
d_rvalid  out  1  load data or store ack, one-cycle pulse
d_rdata  out  32  formatted load data; 0 for stores and errors
d_err  out  1  qualifies d_rvalid: misaligned or illegal width
mem_en  out  1  SRAM access this cycle
mem_we  out  1  SRAM write
mem_addr  out  MEM_AW  SRAM word address
mem_wstrb  out  4  byte write strobes
mem_wdata  out  32  lane-shifted write data
mem_rdata  in  32  SRAM read data, valid the cycle after mem_en

Behaviour:
- Reset (rst=1 at posedge):
  - state IDLE, starvation counter 0, all response/capture registers 0.
  - if_rvalid, d_rvalid, if_err, d_err, if_rdata and d_rdata are 0 the following cycle.
  - Grants and mem_en are 0 while rst=1.
  - Reset during FETCH_HI abandons the fetch; no if_rvalid is issued for it.
- States:
  - IDLE: may grant one requester per cycle.
  - FETCH_HI: second beat of a split fetch; no grants in this state.
- Arbitration in IDLE:
  - Only one of if_req / d_req high: that requester is granted.
  - Both high: data is granted, unless starve_cnt == MAX_DATA_BURST, in which case fetch is granted.
  - starve_cnt increments on each data grant while if_req=1, saturating at MAX_DATA_BURST.
  - starve_cnt clears on a fetch grant or in any cycle with if_req=0.
- Grant cycle T drives the SRAM in the same cycle:
  - mem_addr = addr[MEM_AW+1:2].
  - Response appears at T+1 unless noted below.
  - Back-to-back grants at T+1 are allowed.
- Loads:
  - d_rvalid at T+1.
  - Byte: lane selected by addr[1:0]. Half: lane selected by addr[1].
  - Zero- or sign-extended per d_sign captured at T.
  - Word: raw word.
- Stores:
  - mem_we=1.
  - wstrb: byte 0001<<addr[1:0]; half 0011<<(addr[1]*2); word 1111.
  - mem_wdata = d_wdata shifted left by addr[1:0]*8.
  - d_rvalid pulses at T+1 with d_rdata=0.
- Data errors:
  - Conditions: half with addr[0]=1; word with addr[1:0]!=0; width 11.
  - d_gnt=1 and mem_en=0; d_rvalid with d_err=1 and d_rdata=0 at T+1.
- Fetches:
  - Aligned fetch (addr[1:0]=00): if_rvalid at T+1 with the word.
  - Split fetch (addr[1]=1, addr[0]=0):
    - T: if_gnt=1, read word A; go to FETCH_HI.
    - T+1: read word (A+1) mod 2^MEM_AW; capture mem_rdata[31:16].
    - T+2: if_rvalid=1, if_rdata = {wordA+1[15:0], wordA[31:16]}; return to IDLE, and a new grant is permitted in this cycle.
  - Fetch with addr[0]=1: if_gnt=1, no mem access, if_err=1 at T+1.
- At most one of if_gnt / d_gnt is high in any cycle.
- mem_en is high only in a grant cycle or in FETCH_HI.
- Request inputs are sampled only in the grant cycle; changes after grant have no effect.

Decomposition:
- Shared define file holds:
  - width codes (BYTE=2'b00, HALF=2'b01, WORD=2'b10)
  - arbiter state encodings (IDLE, FETCH_HI)
  - MEM_AW default
- One combinational sub-module, mem_lane_fmt, handles:
  - store strobe and shift generation
  - load lane extract and sign/zero extension
  - misalignment detect
  - Reused by both the request and response paths.

Test Plan:
- Memory preload: word 0x10=0x11223344, word 0x11=0xAABBCCDD.
- Aligned fetch: if_addr=0x40 -> if_gnt at T, if_rvalid at T+1, if_rdata=0x11223344.
- Split fetch: if_addr=0x42 -> mem_addr 0x10 at T, 0x11 at T+1, no d_gnt at T+1 even with d_req=1; if_rvalid at T+2, if_rdata=0xCCDD1122.
- Loads:
  - signed byte 0x44 -> 0xFFFFFFDD
  - unsigned byte 0x43 -> 0x00000011
  - unsigned half 0x46 -> 0x0000AABB
  - signed half 0x46 -> 0xFFFFAABB
- Store then load:
  - store byte 0x41, d_wdata=0x000000EE -> mem_wstrb=0010, mem_wdata=0x0000EE00, d_rvalid at T+1.
  - word load 0x40 -> 0x1122EE44.
- Contention: if_req and d_req held high, MAX_DATA_BURST=4 -> grant order D,D,D,D,F repeating; if_req dropped mid-burst clears the counter.
- Errors and reset:
  - half load 0x41 -> mem_en=0, d_err=1, d_rdata=0.
  - fetch 0x41 -> if_err=1.
  - rst=1 during FETCH_HI -> no if_rvalid; all outputs 0; next if_req granted from IDLE.
